// File: rtl/uart_rx_os16_if.sv
// Host-side byte handshake and error pulses of the 16x-oversampling UART receiver.
// master = receiver (produces bytes), slave = consumer (register/FIFO logic).
interface uart_rx_os16_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  parity_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_os16.sv
// UART receiver: 2-flop rx synchroniser, per-baud 16x tick generator, 8N1 deserialiser with handshake.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx_os16 #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned OS     = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     baud_sel,
    input  logic           rx,
    uart_rx_os16_if.master bus
);
    // Rounded clocks per oversampling tick for each baud rate
    localparam int unsigned DIV_1200 = (CLK_HZ + 1200 * OS / 2) / (1200 * OS);
    localparam int unsigned DIV_2400 = (CLK_HZ + 2400 * OS / 2) / (2400 * OS);
    localparam int unsigned DIV_4800 = (CLK_HZ + 4800 * OS / 2) / (4800 * OS);
    localparam int unsigned DIV_9600 = (CLK_HZ + 9600 * OS / 2) / (9600 * OS);
    localparam int unsigned TW       = $clog2(DIV_1200 + 1);
    localparam int unsigned OSW      = $clog2(OS);
    localparam logic [OSW-1:0] OS_MID  = OSW'(OS / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t         state_q, state_d;
    logic           rx_meta, rxs;
    logic [1:0]     baud_q, baud_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [TW-1:0]  div_m1;
    logic           tick_c;
    logic [OSW-1:0] os_q, os_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
    logic           ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic           par_q, par_d;
    logic           perr_q, perr_d;
`endif

    // Terminal count of the tick counter for the baud latched at the start edge
    always_comb begin
        case (baud_q)
            2'b00:   div_m1 = TW'(DIV_1200 - 1);
            2'b01:   div_m1 = TW'(DIV_2400 - 1);
            2'b10:   div_m1 = TW'(DIV_4800 - 1);
            default: div_m1 = TW'(DIV_9600 - 1);
        endcase
    end

    assign tick_c = (tick_q == div_m1);

    // Next-state, datapath and output pulse logic
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        tick_d  = tick_q;
        os_d    = os_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~bus.rx_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (state_q != IDLE) begin
            tick_d = tick_c ? '0 : tick_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                tick_d = '0;
                os_d   = '0;
                bit_d  = '0;
                if (!rxs) begin
                    baud_d  = baud_sel;
                    state_d = START;
                end
            end
            START: begin
                if (tick_c) begin
                    if (os_q == OS_MID) begin
                        os_d    = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        os_d = os_q + OSW'(1);
                    end
                end
            end
            DATA: begin
                if (tick_c) begin
                    os_d = (os_q == OS_LAST) ? '0 : os_q + OSW'(1);
                    if (os_q == OS_LAST) begin
                        shift_d = {rxs, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_c) begin
                    os_d = (os_q == OS_LAST) ? '0 : os_q + OSW'(1);
                    if (os_q == OS_LAST) begin
                        par_d   = rxs;
                        state_d = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick_c) begin
                    os_d = (os_q == OS_LAST) ? '0 : os_q + OSW'(1);
                    if (os_q == OS_LAST) begin
                        if (rxs) begin
                            // Overwrite even if the previous byte is unread
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            ovr_d   = valid_q & ~bus.rx_ready;
`ifdef UART_RX_PARITY_EN
                            perr_d  = (^shift_q) != par_q;
`endif
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            baud_q  <= 2'b00;
            tick_q  <= '0;
            os_q    <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rx_meta <= rx;
            rxs     <= rx_meta;
            baud_q  <= baud_d;
            tick_q  <= tick_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16 at a reduced 1 MHz clock so that full frames stay short.
// Expected bytes go into a scoreboard queue; the monitor pops and compares them on acceptance.
module tb_uart_rx_os16;
    localparam int unsigned CLK_HZ = 1_000_000;
    // Clocks per tick at 1 MHz: round(1e6/(baud*16))
    localparam int D9600 = 7;
    localparam int D4800 = 13;
    localparam int D2400 = 26;
    localparam int D1200 = 52;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [1:0] baud_sel;
`ifdef UART_RX_PARITY_EN
    logic       par_flip;
`endif

    uart_rx_os16_if bus ();

    uart_rx_os16 #(.CLK_HZ(CLK_HZ), .OS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_sel (baud_sel),
        .rx       (rx),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         cnt_vrise = 0;
    int         cnt_ferr = 0;
    int         cnt_ovr = 0;
    int         cnt_perr = 0;
    int         t_start = 0;
    int         t_valid = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: event counters plus scoreboard compare on each accepted byte
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (!rst) begin
            if (bus.rx_valid && !prev_valid) begin
                cnt_vrise++;
                t_valid = cyc;
            end
            if (bus.frame_err)  cnt_ferr++;
            if (bus.overrun)    cnt_ovr++;
            if (bus.parity_err) cnt_perr++;
            if (bus.rx_valid && bus.rx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected: got byte %02h, expected none", bus.rx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus.rx_data !== exp_b) begin
                        errors++;
                        $display("FAIL scoreboard_data: got %02h, expected %02h", bus.rx_data, exp_b);
                    end
                end
            end
        end
        prev_valid = bus.rx_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; the line is left at the stop-bit level
    task automatic send_frame(input logic [7:0] b, input int div, input logic stop_v);
        int bp;
        bp = 16 * div;
        t_start = cyc;
        rx = 1'b0;
        idle(bp);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(bp);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        idle(bp);
`endif
        rx = stop_v;
        idle(bp);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        idle(1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        baud_sel = 2'b11;
        bus.rx_ready = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        idle(5);
        rst = 1'b0;
        idle(2);
        checks += 5;
        if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.rx_valid); end
        if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", bus.rx_data); end
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, expected 0", bus.frame_err); end
        if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, expected 0", bus.overrun); end
        if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b, expected 0", bus.parity_err); end
    endtask

    // One byte per baud rate with rx_ready=1; checks data, pulses and start-to-valid latency
    task automatic test_bauds;
        logic [1:0] sel [3] = '{2'b11, 2'b10, 2'b01};
        int         dv  [3] = '{D9600, D4800, D2400};
        logic [7:0] byt [3] = '{8'hA5, 8'h69, 8'h0F};
        int v0, f0, o0, lat, lexp;
        bus.rx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            baud_sel = sel[k];
            v0 = cnt_vrise; f0 = cnt_ferr; o0 = cnt_ovr;
            exp_q.push_back(byt[k]);
            send_frame(byt[k], dv[k], 1'b1);
            wait_drain(4 * 16 * dv[k]);
            lat  = t_valid - t_start;
            lexp = 3 + 152 * dv[k];
            checks += 4;
            if (exp_q.size() != 0) begin errors++; $display("FAIL bauds_timeout[%0d]: %0d bytes pending, expected 0", k, exp_q.size()); exp_q.delete(); end
            if (cnt_vrise - v0 != 1) begin errors++; $display("FAIL bauds_valid_count[%0d]: got %0d, expected 1", k, cnt_vrise - v0); end
            if (cnt_ferr != f0 || cnt_ovr != o0) begin errors++; $display("FAIL bauds_err_pulse[%0d]: ferr %0d ovr %0d, expected 0 0", k, cnt_ferr - f0, cnt_ovr - o0); end
            if (lat < lexp - 4 || lat > lexp + 4) begin errors++; $display("FAIL bauds_latency[%0d]: got %0d, expected %0d+-4", k, lat, lexp); end
        end
    endtask

    // 1200 baud with rx_ready low: byte held until accepted
    task automatic test_slow_hold;
        int lat;
        bus.rx_ready = 1'b0;
        baud_sel = 2'b00;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, D1200, 1'b1);
        idle(200);
        lat = t_valid - t_start;
        checks += 3;
        if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL slow_valid_held: got %b, expected 1", bus.rx_valid); end
        if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL slow_data: got %02h, expected 3c", bus.rx_data); end
        if (lat < 3 + 152 * D1200 - 4 || lat > 3 + 152 * D1200 + 4) begin errors++; $display("FAIL slow_latency: got %0d, expected %0d+-4", lat, 3 + 152 * D1200); end
        bus.rx_ready = 1'b1;
        wait_drain(10);
        idle(1);
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL slow_accept: %0d bytes pending, expected 0", exp_q.size()); exp_q.delete(); end
        if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL slow_valid_clear: got %b, expected 0", bus.rx_valid); end
        baud_sel = 2'b11;
    endtask

    task automatic test_back_to_back;
        int o0, v0;
        bus.rx_ready = 1'b0;
        o0 = cnt_ovr; v0 = cnt_vrise;
        exp_q.push_back(8'h22);
        send_frame(8'h11, D9600, 1'b1);
        send_frame(8'h22, D9600, 1'b1);
        idle(20);
        checks += 4;
        if (cnt_ovr - o0 != 1) begin errors++; $display("FAIL b2b_overrun: got %0d pulses, expected 1", cnt_ovr - o0); end
        if (cnt_vrise - v0 != 1) begin errors++; $display("FAIL b2b_valid_rises: got %0d, expected 1", cnt_vrise - v0); end
        if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b, expected 1", bus.rx_valid); end
        if (bus.rx_data !== 8'h22) begin errors++; $display("FAIL b2b_data: got %02h, expected 22", bus.rx_data); end
        bus.rx_ready = 1'b1;
        wait_drain(10);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d bytes pending, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_frame_err;
        int f0, v0;
        f0 = cnt_ferr; v0 = cnt_vrise;
        send_frame(8'h81, D9600, 1'b0);
        idle(500);
        checks += 2;
        if (cnt_ferr - f0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d pulses, expected 1", cnt_ferr - f0); end
        if (cnt_vrise != v0) begin errors++; $display("FAIL ferr_no_valid: got %0d rises, expected 0", cnt_vrise - v0); end
        rx = 1'b1;
        idle(2 * 16 * D9600);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, D9600, 1'b1);
        wait_drain(4 * 16 * D9600);
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ferr_recover: %0d bytes pending, expected 0", exp_q.size()); exp_q.delete(); end
        if (cnt_ferr - f0 != 1) begin errors++; $display("FAIL ferr_once: got %0d pulses, expected 1", cnt_ferr - f0); end
    endtask

    task automatic test_glitch;
        int v0, f0, o0;
        v0 = cnt_vrise; f0 = cnt_ferr; o0 = cnt_ovr;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(3 * 16 * D9600);
        checks++;
        if (cnt_vrise != v0 || cnt_ferr != f0 || cnt_ovr != o0) begin
            errors++;
            $display("FAIL glitch_quiet: valid %0d ferr %0d ovr %0d, expected 0 0 0", cnt_vrise - v0, cnt_ferr - f0, cnt_ovr - o0);
        end
        exp_q.push_back(8'h96);
        send_frame(8'h96, D9600, 1'b1);
        wait_drain(4 * 16 * D9600);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_next_frame: %0d bytes pending, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid;
        int v0, f0, o0;
        v0 = cnt_vrise; f0 = cnt_ferr; o0 = cnt_ovr;
        rx = 1'b0;
        idle(4 * 16 * D9600);
        rx = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(12 * 16 * D9600);
        checks += 2;
        if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, expected 0", bus.rx_valid); end
        if (cnt_vrise != v0 || cnt_ferr != f0 || cnt_ovr != o0) begin
            errors++;
            $display("FAIL rstmid_quiet: valid %0d ferr %0d ovr %0d, expected 0 0 0", cnt_vrise - v0, cnt_ferr - f0, cnt_ovr - o0);
        end
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, D9600, 1'b1);
        wait_drain(4 * 16 * D9600);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_next_frame: %0d bytes pending, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    // baud_sel changed mid-frame must not disturb the frame in flight
    task automatic test_baud_latch;
        exp_q.push_back(8'hC3);
        fork
            send_frame(8'hC3, D9600, 1'b1);
            begin
                idle(3 * 16 * D9600);
                baud_sel = 2'b00;
            end
        join
        wait_drain(4 * 16 * D9600);
        baud_sel = 2'b11;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL latch_frame: %0d bytes pending, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_parity;
        int p0;
        p0 = cnt_perr;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        exp_q.push_back(8'h07);
        send_frame(8'h07, D9600, 1'b1);
        wait_drain(4 * 16 * D9600);
        par_flip = 1'b0;
        checks += 2;
        if (cnt_perr - p0 != 1) begin errors++; $display("FAIL parity_pulse: got %0d pulses, expected 1", cnt_perr - p0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL parity_byte: %0d bytes pending, expected 0", exp_q.size()); exp_q.delete(); end
        p0 = cnt_perr;
        exp_q.push_back(8'h03);
        send_frame(8'h03, D9600, 1'b1);
        wait_drain(4 * 16 * D9600);
        checks++;
        if (cnt_perr != p0) begin errors++; $display("FAIL parity_good: got %0d pulses, expected 0", cnt_perr - p0); end
`else
        checks++;
        if (cnt_perr != 0) begin errors++; $display("FAIL parity_tied: got %0d pulses, expected 0", cnt_perr); end
`endif
    endtask

    initial begin
        test_reset();
        test_bauds();
        test_slow_hold();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_baud_latch();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 95000 cycles, expected completion");
        $fatal(1);
    end
endmodule
